// File: rtl/axil_ram_bank.sv
// rtl/axil_ram_bank.sv - AXI4-Lite slave over a byte-strobed on-chip RAM
// Optional: define AXIL_RAM_ZERO_INIT_EN to clear every word at time zero.
module axil_ram_bank #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 16,
    parameter int STRB_WIDTH      = DATA_WIDTH / 8,
    parameter int PIPELINE_OUTPUT = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic [2:0]            s_axil_awprot,
    input  logic                  s_axil_awvalid,
    output logic                  s_axil_awready,
    input  logic [DATA_WIDTH-1:0] s_axil_wdata,
    input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
    input  logic                  s_axil_wvalid,
    output logic                  s_axil_wready,
    output logic [1:0]            s_axil_bresp,
    output logic                  s_axil_bvalid,
    input  logic                  s_axil_bready,
    input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic [2:0]            s_axil_arprot,
    input  logic                  s_axil_arvalid,
    output logic                  s_axil_arready,
    output logic [DATA_WIDTH-1:0] s_axil_rdata,
    output logic [1:0]            s_axil_rresp,
    output logic                  s_axil_rvalid,
    input  logic                  s_axil_rready
);
    localparam int WORD_SHIFT = $clog2(STRB_WIDTH);
    localparam int WORD_AW    = ADDR_WIDTH - WORD_SHIFT;

    logic [DATA_WIDTH-1:0] mem [2**WORD_AW];

    logic [WORD_AW-1:0]    wr_idx;
    logic [WORD_AW-1:0]    rd_idx;
    logic                  wr_accept;
    logic                  rd_accept;
    logic                  out_ready;
    logic                  s1_ready;
    logic [DATA_WIDTH-1:0] rd_q;
    logic                  rv_q;
    logic                  unused_bits;

`ifdef AXIL_RAM_ZERO_INIT_EN
    initial begin
        for (int i = 0; i < 2**WORD_AW; i++) begin
            mem[i] = '0;
        end
    end
`else
    // Unwritten words keep whatever the device powers up with.
`endif

    assign wr_idx        = s_axil_awaddr[ADDR_WIDTH-1:WORD_SHIFT];
    assign rd_idx        = s_axil_araddr[ADDR_WIDTH-1:WORD_SHIFT];
    assign s_axil_wready = s_axil_awready;
    assign s_axil_bresp  = 2'b00;
    assign s_axil_rresp  = 2'b00;
    assign unused_bits   = ^{s_axil_awprot, s_axil_arprot, s_axil_awaddr, s_axil_araddr};

    always_comb begin
        wr_accept = s_axil_awvalid && s_axil_wvalid && !s_axil_awready &&
                    (!s_axil_bvalid || s_axil_bready);
        out_ready = !s_axil_rvalid || s_axil_rready;
        // With the extra stage, stage 1 may refill while stage 2 still holds data.
        s1_ready  = (PIPELINE_OUTPUT != 0) ? (!rv_q || out_ready) : out_ready;
        rd_accept = s_axil_arvalid && !s_axil_arready && s1_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_axil_awready <= 1'b0;
            s_axil_bvalid  <= 1'b0;
        end else begin
            s_axil_awready <= wr_accept;
            if (wr_accept) begin
                s_axil_bvalid <= 1'b1;
            end else if (s_axil_bready) begin
                s_axil_bvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < STRB_WIDTH; i++) begin
            if (!rst && wr_accept && s_axil_wstrb[i]) begin
                mem[wr_idx][8*i +: 8] <= s_axil_wdata[8*i +: 8];
            end
        end
    end

    // Stage 1 always empties when the output side takes it, in either configuration.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_axil_arready <= 1'b0;
            rv_q           <= 1'b0;
            rd_q           <= '0;
        end else begin
            s_axil_arready <= rd_accept;
            if (rd_accept) begin
                rv_q <= 1'b1;
                rd_q <= mem[rd_idx];
            end else if (out_ready) begin
                rv_q <= 1'b0;
            end
        end
    end

    if (PIPELINE_OUTPUT != 0) begin : g_pipe
        logic [DATA_WIDTH-1:0] rd_p;
        logic                  rv_p;

        always_ff @(posedge clk) begin
            if (rst) begin
                rv_p <= 1'b0;
                rd_p <= '0;
            end else if (out_ready) begin
                rv_p <= rv_q;
                if (rv_q) begin
                    rd_p <= rd_q;
                end
            end
        end

        assign s_axil_rdata  = rd_p;
        assign s_axil_rvalid = rv_p;
    end else begin : g_direct
        assign s_axil_rdata  = rd_q;
        assign s_axil_rvalid = rv_q;
    end
endmodule

// File: tb/tb_axil_ram_bank.sv
// tb/tb_axil_ram_bank.sv - directed bench for axil_ram_bank, direct and pipelined read paths
module tb_axil_ram_bank;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        bready;
    logic [2:0]  arprot;
    logic [1:0]  awready, wready, bvalid, arready, rvalid, arvalid, rready;
    logic [1:0]  bresp [2];
    logic [1:0]  rresp [2];
    logic [15:0] araddr [2];
    logic [31:0] rdata [2];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    axil_ram_bank #(.PIPELINE_OUTPUT(0)) dut0 (
        .clk(clk), .rst(rst),
        .s_axil_awaddr(awaddr), .s_axil_awprot(awprot), .s_axil_awvalid(awvalid),
        .s_axil_awready(awready[0]), .s_axil_wdata(wdata), .s_axil_wstrb(wstrb),
        .s_axil_wvalid(wvalid), .s_axil_wready(wready[0]), .s_axil_bresp(bresp[0]),
        .s_axil_bvalid(bvalid[0]), .s_axil_bready(bready),
        .s_axil_araddr(araddr[0]), .s_axil_arprot(arprot), .s_axil_arvalid(arvalid[0]),
        .s_axil_arready(arready[0]), .s_axil_rdata(rdata[0]), .s_axil_rresp(rresp[0]),
        .s_axil_rvalid(rvalid[0]), .s_axil_rready(rready[0])
    );

    axil_ram_bank #(.PIPELINE_OUTPUT(1)) dut1 (
        .clk(clk), .rst(rst),
        .s_axil_awaddr(awaddr), .s_axil_awprot(awprot), .s_axil_awvalid(awvalid),
        .s_axil_awready(awready[1]), .s_axil_wdata(wdata), .s_axil_wstrb(wstrb),
        .s_axil_wvalid(wvalid), .s_axil_wready(wready[1]), .s_axil_bresp(bresp[1]),
        .s_axil_bvalid(bvalid[1]), .s_axil_bready(bready),
        .s_axil_araddr(araddr[1]), .s_axil_arprot(arprot), .s_axil_arvalid(arvalid[1]),
        .s_axil_arready(arready[1]), .s_axil_rdata(rdata[1]), .s_axil_rresp(rresp[1]),
        .s_axil_rvalid(rvalid[1]), .s_axil_rready(rready[1])
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Entered and left on a falling edge; both write instances see the same stimulus.
    task automatic axil_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                              output logic [1:0] resp);
        int t = 0;
        bit aw_done = 0;
        bit b_done = 0;
        resp = 2'bxx;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        while (!b_done && t < 50) begin
            if (!aw_done && awready[0] && wready[0]) aw_done = 1;
            if (aw_done && bvalid[0]) begin
                b_done = 1;
                resp = bresp[0];
            end
            @(negedge clk);
            t++;
            if (aw_done) begin
                awvalid = 1'b0;
                wvalid = 1'b0;
            end
        end
        awvalid = 1'b0;
        wvalid = 1'b0;
        check("wr_complete", 64'(b_done), 64'd1);
    endtask

    task automatic axil_read(input int i, input logic [15:0] a, output logic [31:0] d,
                             output logic [1:0] resp);
        int t = 0;
        bit ar_done = 0;
        bit got = 0;
        d = 'x;
        resp = 2'bxx;
        araddr[i] = a; arvalid[i] = 1'b1; rready[i] = 1'b1;
        while (!got && t < 50) begin
            if (!ar_done && arready[i]) ar_done = 1;
            if (ar_done && rvalid[i]) begin
                got = 1;
                d = rdata[i];
                resp = rresp[i];
            end
            @(negedge clk);
            t++;
            if (ar_done) arvalid[i] = 1'b0;
        end
        arvalid[i] = 1'b0;
        check("rd_complete", 64'(got), 64'd1);
    endtask

    // Reads 0x0, 0x4, 0x8 back to back while rready toggles every cycle.
    task automatic burst(input int i, input logic [31:0] e0, input logic [31:0] e1,
                         input logic [31:0] e2);
        logic [31:0] got [3];
        logic [31:0] held = '0;
        int n = 0;
        int cyc = 0;
        int extra = 0;
        bit stalled = 0;
        fork
            begin
                for (int k = 0; k < 3; k++) begin
                    int t = 0;
                    araddr[i] = 16'(4 * k);
                    arvalid[i] = 1'b1;
                    while (!arready[i] && t < 40) begin
                        @(negedge clk);
                        t++;
                    end
                    check("burst_ar_wait", 64'(t < 40), 64'd1);
                    @(negedge clk);
                end
                arvalid[i] = 1'b0;
            end
            begin
                while (n < 3 && cyc < 80) begin
                    if (stalled) begin
                        check("burst_hold_valid", 64'(rvalid[i]), 64'd1);
                        check("burst_hold_data", 64'(rdata[i]), 64'(held));
                    end
                    rready[i] = (cyc % 2 == 0);
                    stalled = rvalid[i] && !rready[i];
                    held = rdata[i];
                    if (rvalid[i] && rready[i]) begin
                        got[n] = rdata[i];
                        n++;
                    end
                    @(negedge clk);
                    cyc++;
                end
            end
        join
        check("burst_count", 64'(n), 64'd3);
        check("burst_d0", 64'(got[0]), 64'(e0));
        check("burst_d1", 64'(got[1]), 64'(e1));
        check("burst_d2", 64'(got[2]), 64'(e2));
        rready[i] = 1'b1;
        repeat (4) begin
            if (rvalid[i]) extra++;
            @(negedge clk);
        end
        check("burst_no_dup", 64'(extra), 64'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic [1:0]  rr;
        logic [1:0]  br;
        logic [1:0]  seen;
        bit          hold_seen;
        int          t;

        rst = 1'b1;
        awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
        bready = 1'b0; arprot = '0; arvalid = '0; rready = '0;
        araddr[0] = '0; araddr[1] = '0;
        repeat (3) @(negedge clk);
        check("reset_ctrl", 64'({awready, wready, bvalid, arready, rvalid}), 64'd0);
        check("reset_rdata0", 64'(rdata[0]), 64'd0);
        check("reset_rdata1", 64'(rdata[1]), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        axil_write(16'h0000, 32'h1122_3344, 4'hF, br);
        check("full_bresp", 64'(br), 64'd0);
        axil_read(0, 16'h0000, rd, rr);
        check("full_rdata", 64'(rd), 64'h1122_3344);
        check("full_rresp", 64'(rr), 64'd0);

        axil_write(16'h0004, 32'h1122_3344, 4'hF, br);
        axil_write(16'h0004, 32'hAABB_CCDD, 4'h5, br);
        axil_read(0, 16'h0004, rd, rr);
        check("strb_merge", 64'(rd), 64'h11BB_33DD);

        axil_write(16'h0009, 32'hDEAD_BEEF, 4'hF, br);
        axil_read(0, 16'h0008, rd, rr);
        check("unaligned", 64'(rd), 64'hDEAD_BEEF);

        axil_write(16'hFFFE, 32'h55AA_55AA, 4'hF, br);
        axil_read(1, 16'hFFFC, rd, rr);
        check("top_word_pipe", 64'(rd), 64'h55AA_55AA);

        // Write response back-pressure blocks the next write.
        awaddr = 16'h0010; wdata = 32'hA5A5_0001; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        t = 0;
        while (!(awready[0] && wready[0]) && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("bp_first_accept", 64'(t < 20), 64'd1);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        check("bp_bvalid_held", 64'(bvalid[0]), 64'd1);
        awaddr = 16'h0014; wdata = 32'hA5A5_0002; awvalid = 1'b1; wvalid = 1'b1;
        hold_seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (awready[0] || wready[0]) hold_seen = 1;
        end
        check("bp_ready_blocked", 64'(hold_seen), 64'd0);
        check("bp_bvalid_still", 64'(bvalid[0]), 64'd1);
        axil_write(16'h0014, 32'hA5A5_0002, 4'hF, br);
        check("bp_second_bresp", 64'(br), 64'd0);
        axil_read(0, 16'h0010, rd, rr);
        check("bp_word0", 64'(rd), 64'hA5A5_0001);
        axil_read(0, 16'h0014, rd, rr);
        check("bp_word1", 64'(rd), 64'hA5A5_0002);

        // Same-cycle read and write of one word returns the old contents.
        axil_write(16'h000C, 32'h0102_0304, 4'hF, br);
        fork
            axil_write(16'h000C, 32'hCAFE_F00D, 4'hF, br);
            axil_read(0, 16'h000C, rd, rr);
        join
        check("rbw_old", 64'(rd), 64'h0102_0304);
        axil_read(0, 16'h000C, rd, rr);
        check("rbw_new", 64'(rd), 64'hCAFE_F00D);

        burst(0, 32'h1122_3344, 32'h11BB_33DD, 32'hDEAD_BEEF);
        burst(1, 32'h1122_3344, 32'h11BB_33DD, 32'hDEAD_BEEF);

        // Reset with a write response and read data both pending.
        awaddr = 16'h0020; wdata = 32'h600D_D00D; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        t = 0;
        while (!awready[0] && t < 20) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        araddr[0] = 16'h0020; araddr[1] = 16'h0020;
        arvalid = 2'b11; rready = 2'b00;
        seen = 2'b00;
        t = 0;
        while (!(rvalid[0] && rvalid[1]) && t < 20) begin
            for (int i = 0; i < 2; i++) if (arready[i]) seen[i] = 1'b1;
            @(negedge clk);
            t++;
            for (int i = 0; i < 2; i++) if (seen[i]) arvalid[i] = 1'b0;
        end
        arvalid = 2'b00;
        check("pre_rst_pending", 64'({bvalid[0], bvalid[1], rvalid[0], rvalid[1]}), 64'hF);
        rst = 1'b1;
        @(negedge clk);
        check("rst_drop", 64'({bvalid, rvalid, awready, arready}), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        axil_read(0, 16'h0020, rd, rr);
        check("rst_keep_direct", 64'(rd), 64'h600D_D00D);
        axil_read(1, 16'h0020, rd, rr);
        check("rst_keep_pipe", 64'(rd), 64'h600D_D00D);
        axil_read(1, 16'h0000, rd, rr);
        check("rst_keep_old", 64'(rd), 64'h1122_3344);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/axil_ram_bank.md
Name: axil_ram_bank

Overview:
- AXI4-Lite slave backed by an on-chip RAM of 2^ADDR_WIDTH bytes, organised as DATA_WIDTH-bit words.
- Independent write and read channels, so one write and one read can complete in the same cycle.
- Used as a register/scratch memory or as a test target on AXI-Lite interconnects.

Parameters:
- DATA_WIDTH, 32, data bus width in bits; must be a multiple of 8.
- ADDR_WIDTH, 16, byte address width.
- STRB_WIDTH, DATA_WIDTH/8, write strobe width; must equal DATA_WIDTH/8.
- PIPELINE_OUTPUT, 0, when 1 adds one extra register stage on the read data path.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- s_axil_awaddr  in  ADDR_WIDTH  write address (byte).
- s_axil_awprot  in  3  ignored.
- s_axil_awvalid  in  1  write address valid.
- s_axil_awready  out  1  write address ready.
- s_axil_wdata  in  DATA_WIDTH  write data.
- s_axil_wstrb  in  STRB_WIDTH  byte enables.
- s_axil_wvalid  in  1  write data valid.
- s_axil_wready  out  1  write data ready.
- s_axil_bresp  out  2  write response; always 2'b00 (OKAY).
- s_axil_bvalid  out  1  write response valid.
- s_axil_bready  in  1  write response ready.
- s_axil_araddr  in  ADDR_WIDTH  read address (byte).
- s_axil_arprot  in  3  ignored.
- s_axil_arvalid  in  1  read address valid.
- s_axil_arready  out  1  read address ready.
- s_axil_rdata  out  DATA_WIDTH  read data.
- s_axil_rresp  out  2  read response; always 2'b00.
- s_axil_rvalid  out  1  read data valid.
- s_axil_rready  in  1  read data ready.

Behaviour:
- Word index = addr >> log2(STRB_WIDTH), using ADDR_WIDTH-log2(STRB_WIDTH) bits. The low byte-offset bits are ignored (unaligned accesses are treated as aligned). Every address is in range, so there is no error response.
- Reset values: awready, wready, bvalid, arready, rvalid = 0; rdata = 0. Memory contents are not affected by reset.
- Write path:
  - The slave accepts a write only when awvalid && wvalid are both high, awready is currently 0, and (!bvalid || bready).
  - In that case awready and wready are both driven 1 for exactly one cycle, so AW and W handshake together.
  - In the same edge, each byte i of the addressed word is written from wdata[8i+7:8i] where wstrb[i]=1. Bytes with wstrb[i]=0 are unchanged.
  - bvalid rises on the cycle after the handshake and is held until bvalid && bready. With bready held high, a new write is accepted every 2 cycles.
- Read path:
  - The slave accepts a read only when arvalid is high, arready is currently 0, and the output stage can accept data: !rvalid || rready.
  - arready is then driven 1 for exactly one cycle. Memory is read at that edge, and rdata/rvalid are valid on the next cycle.
  - rdata and rvalid hold stable until rready.
- PIPELINE_OUTPUT=1:
  - A second output register adds one cycle of read latency.
  - Stage 1 advances into stage 2 when stage 2 is empty or is being drained by rready. arready back-pressure is based on stage 1 occupancy.
  - No read is lost or duplicated under arbitrary rready stalls.
- Simultaneous read and write:
  - Both proceed independently.
  - A read of the word being written in the same cycle returns the old data (read-before-write).
- Reset mid-transaction drops pending bvalid/rvalid with no response. RAM contents are retained.

Optional Feature:
- AXIL_RAM_ZERO_INIT_EN
  - Defined: every memory word is initialised to 0 at time zero, so reads of never-written locations return 0.
  - Undefined: no initial block; unwritten contents are unspecified (X in simulation, device default in synthesis).

Test Plan:
- Write 0x11223344 to 0x0000 with wstrb=0xF, then read 0x0000 -> bresp=0, rdata=0x11223344, rresp=0.
- Write 0xAABBCCDD to 0x0004 with wstrb=0x5 over prior 0x11223344 -> read returns 0x11BB33DD.
- Write 0xDEADBEEF to 0x0009 (unaligned) -> read of 0x0008 returns 0xDEADBEEF.
- Hold bready=0 after a write, present a second write -> awready/wready stay 0 until bready, then the second write completes.
- Three back-to-back reads of 0x0,0x4,0x8 with rready toggling 1,0,1 (both PIPELINE_OUTPUT=0 and 1) -> data returned in order, none dropped or duplicated.
- Assert rst while bvalid=1 and rvalid=1 -> both 0 next cycle; a subsequent read returns the data written before reset.
